// File: rtl/decode_stage_if.sv
// Signal bundle between the fetch buffer / writeback path and the decode stage,
// together with the ID/EX pipeline-buffer outputs.
interface decode_stage_if #(
  parameter int DATA_W = 32,
  parameter int ALUC_W = 4
);
  logic              validIn_ID;
  logic [5:0]        opID;
  logic [4:0]        rsID;
  logic [4:0]        rtID;
  logic [4:0]        rdID;
  logic [4:0]        shamtID;
  logic [5:0]        functID;
  logic              flush_ID;
  logic              wbEn_ID;
  logic [4:0]        wbAddr_ID;
  logic [DATA_W-1:0] wbData_ID;

  logic              stall_ID;
  logic              validEX;
  logic [DATA_W-1:0] rsDataEX;
  logic [DATA_W-1:0] rtDataEX;
  logic [DATA_W-1:0] immEX;
  logic [4:0]        rsEX;
  logic [4:0]        rtEX;
  logic [4:0]        destEX;
  logic [4:0]        shamtEX;
  logic [ALUC_W-1:0] aluCtrlEX;
  logic              regWriteEX;
  logic              memReadEX;
  logic              memWriteEX;
  logic              memToRegEX;
  logic              aluSrcEX;
  logic              branchEX;
  logic              illegalEX;

  modport master (
    output validIn_ID, opID, rsID, rtID, rdID, shamtID, functID, flush_ID,
           wbEn_ID, wbAddr_ID, wbData_ID,
    input  stall_ID, validEX, rsDataEX, rtDataEX, immEX, rsEX, rtEX, destEX,
           shamtEX, aluCtrlEX, regWriteEX, memReadEX, memWriteEX, memToRegEX,
           aluSrcEX, branchEX, illegalEX
  );

  modport slave (
    input  validIn_ID, opID, rsID, rtID, rdID, shamtID, functID, flush_ID,
           wbEn_ID, wbAddr_ID, wbData_ID,
    output stall_ID, validEX, rsDataEX, rtDataEX, immEX, rsEX, rtEX, destEX,
           shamtEX, aluCtrlEX, regWriteEX, memReadEX, memWriteEX, memToRegEX,
           aluSrcEX, branchEX, illegalEX
  );
endinterface

// File: rtl/decode_stage.sv
// Instruction decode: register-file read with writeback bypass, control decode,
// load-use hazard detection and the ID/EX pipeline buffer.
module decode_stage #(
  parameter int DATA_W = 32,
  parameter int ALUC_W = 4
) (
  input logic           clk_ID,
  input logic           rstn_ID,
  decode_stage_if.slave bus
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [ALUC_W-1:0] ALU_AND = ALUC_W'(4'b0000);
  localparam logic [ALUC_W-1:0] ALU_OR  = ALUC_W'(4'b0001);
  localparam logic [ALUC_W-1:0] ALU_ADD = ALUC_W'(4'b0010);
  localparam logic [ALUC_W-1:0] ALU_SUB = ALUC_W'(4'b0110);
  localparam logic [ALUC_W-1:0] ALU_SLT = ALUC_W'(4'b0111);
  localparam logic [ALUC_W-1:0] ALU_SLL = ALUC_W'(4'b1000);
  localparam logic [ALUC_W-1:0] ALU_SRL = ALUC_W'(4'b1001);

  typedef struct packed {
    logic [ALUC_W-1:0] aluCtrl;
    logic              regWrite;
    logic              memRead;
    logic              memWrite;
    logic              memToReg;
    logic              aluSrc;
    logic              branch;
    logic              illegal;
  } ctrl_t;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] rsData;
    logic [DATA_W-1:0] rtData;
    logic [DATA_W-1:0] imm;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        dest;
    logic [4:0]        shamt;
    ctrl_t             ctrl;
  } idex_t;

  logic [DATA_W-1:0] regFile [32];
  logic [DATA_W-1:0] rsData;
  logic [DATA_W-1:0] rtData;
  logic [15:0]       imm16;
  logic [DATA_W-1:0] immExt;
  ctrl_t             ctrl;
  logic [4:0]        dest;
  logic              readsRt;
  logic              stall;
  idex_t             exReg;
  idex_t             exNext;

  // NOTE: every register is cleared on reset because software relies on all
  // registers reading 0 afterwards; a plain data memory would not be reset.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_ID or negedge rstn_ID) begin
    if (!rstn_ID) begin
      for (int i = 0; i < 32; i++) regFile[i] <= '0;
    end else if (bus.wbEn_ID && bus.wbAddr_ID != 5'd0) begin
      regFile[bus.wbAddr_ID] <= bus.wbData_ID;
    end
  end

  // $0 is hardwired; a same-cycle writeback to the read register wins over the array.
  assign rsData = (bus.rsID == 5'd0) ? '0 :
                  (bus.wbEn_ID && bus.wbAddr_ID == bus.rsID) ? bus.wbData_ID :
                  regFile[bus.rsID];
  assign rtData = (bus.rtID == 5'd0) ? '0 :
                  (bus.wbEn_ID && bus.wbAddr_ID == bus.rtID) ? bus.wbData_ID :
                  regFile[bus.rtID];

  assign imm16  = {bus.rdID, bus.shamtID, bus.functID};
  assign immExt = {{(DATA_W-16){imm16[15]}}, imm16};

  // NOTE: defaults at the top of every combinational block keep it latch-free.
  always_comb begin
    ctrl    = '0;
    dest    = '0;
    readsRt = 1'b0;
    unique case (bus.opID)
      OP_RTYPE: begin
        readsRt       = 1'b1;
        dest          = bus.rdID;
        ctrl.regWrite = 1'b1;
        unique case (bus.functID)
          FN_ADD:  ctrl.aluCtrl = ALU_ADD;
          FN_SUB:  ctrl.aluCtrl = ALU_SUB;
          FN_AND:  ctrl.aluCtrl = ALU_AND;
          FN_OR:   ctrl.aluCtrl = ALU_OR;
          FN_SLT:  ctrl.aluCtrl = ALU_SLT;
          FN_SLL:  ctrl.aluCtrl = ALU_SLL;
          FN_SRL:  ctrl.aluCtrl = ALU_SRL;
          default: begin
            ctrl.regWrite = 1'b0;
            ctrl.illegal  = 1'b1;
            dest          = '0;
          end
        endcase
      end
      OP_ADDI: begin
        ctrl.aluCtrl  = ALU_ADD;
        ctrl.aluSrc   = 1'b1;
        ctrl.regWrite = 1'b1;
        dest          = bus.rtID;
      end
      OP_LW: begin
        ctrl.aluCtrl  = ALU_ADD;
        ctrl.aluSrc   = 1'b1;
        ctrl.memRead  = 1'b1;
        ctrl.memToReg = 1'b1;
        ctrl.regWrite = 1'b1;
        dest          = bus.rtID;
      end
      OP_SW: begin
        readsRt       = 1'b1;
        ctrl.aluCtrl  = ALU_ADD;
        ctrl.aluSrc   = 1'b1;
        ctrl.memWrite = 1'b1;
      end
      OP_BEQ: begin
        readsRt      = 1'b1;
        ctrl.aluCtrl = ALU_SUB;
        ctrl.branch  = 1'b1;
      end
      default: ctrl.illegal = 1'b1;
    endcase
    if (dest == 5'd0) ctrl.regWrite = 1'b0;
  end

  assign stall = bus.validIn_ID && exReg.valid && exReg.ctrl.memRead &&
                 (exReg.dest != 5'd0) &&
                 ((exReg.dest == bus.rsID) || ((exReg.dest == bus.rtID) && readsRt));

  // Flush, stall and an empty BF0 all collapse to the same all-zero bubble.
  always_comb begin
    exNext = '0;
    if (!bus.flush_ID && !stall && bus.validIn_ID) begin
      exNext.valid  = 1'b1;
      exNext.rsData = rsData;
      exNext.rtData = rtData;
      exNext.imm    = immExt;
      exNext.rs     = bus.rsID;
      exNext.rt     = bus.rtID;
      exNext.dest   = dest;
      exNext.shamt  = bus.shamtID;
      exNext.ctrl   = ctrl;
    end
  end

  always_ff @(posedge clk_ID or negedge rstn_ID) begin
    if (!rstn_ID) exReg <= '0;
    else          exReg <= exNext;
  end

  assign bus.stall_ID   = stall;
  assign bus.validEX    = exReg.valid;
  assign bus.rsDataEX   = exReg.rsData;
  assign bus.rtDataEX   = exReg.rtData;
  assign bus.immEX      = exReg.imm;
  assign bus.rsEX       = exReg.rs;
  assign bus.rtEX       = exReg.rt;
  assign bus.destEX     = exReg.dest;
  assign bus.shamtEX    = exReg.shamt;
  assign bus.aluCtrlEX  = exReg.ctrl.aluCtrl;
  assign bus.regWriteEX = exReg.ctrl.regWrite;
  assign bus.memReadEX  = exReg.ctrl.memRead;
  assign bus.memWriteEX = exReg.ctrl.memWrite;
  assign bus.memToRegEX = exReg.ctrl.memToReg;
  assign bus.aluSrcEX   = exReg.ctrl.aluSrc;
  assign bus.branchEX   = exReg.ctrl.branch;
  assign bus.illegalEX  = exReg.ctrl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios with literal expectations, then
// randomized traffic against an instruction-level reference model.
module tb_decode_stage;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  decode_stage_if #(.DATA_W(32), .ALUC_W(4)) bus ();
  decode_stage #(.DATA_W(32), .ALUC_W(4)) dut (.clk_ID(clk), .rstn_ID(rstn), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [31:0] rsData;
    logic [31:0] rtData;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [4:0]  shamt;
    logic [3:0]  aluCtrl;
    logic        regWrite;
    logic        memRead;
    logic        memWrite;
    logic        memToReg;
    logic        aluSrc;
    logic        branch;
    logic        illegal;
  } exp_t;

  int          nChecks = 0;
  int          nPass   = 0;
  logic [31:0] mRegs [32];
  exp_t        mEx;

  function automatic exp_t actualEx();
    exp_t a;
    a = {bus.validEX, bus.rsDataEX, bus.rtDataEX, bus.immEX, bus.rsEX, bus.rtEX,
         bus.destEX, bus.shamtEX, bus.aluCtrlEX, bus.regWriteEX, bus.memReadEX,
         bus.memWriteEX, bus.memToRegEX, bus.aluSrcEX, bus.branchEX, bus.illegalEX};
    return a;
  endfunction

  function automatic logic [31:0] mRead(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (bus.wbEn_ID && bus.wbAddr_ID == a) return bus.wbData_ID;
    return mRegs[a];
  endfunction

  function automatic logic mStall();
    logic readsRt;
    readsRt = (bus.opID == 6'h00) || (bus.opID == 6'h2B) || (bus.opID == 6'h04);
    return bus.validIn_ID && mEx.valid && mEx.memRead && (mEx.dest != 5'd0) &&
           ((mEx.dest == bus.rsID) || ((mEx.dest == bus.rtID) && readsRt));
  endfunction

  // What the ID/EX buffer must hold after the next edge, from the instruction set rules.
  function automatic exp_t mNext();
    exp_t e;
    e = '0;
    if (bus.flush_ID || mStall() || !bus.validIn_ID) return e;
    e.valid  = 1'b1;
    e.rsData = mRead(bus.rsID);
    e.rtData = mRead(bus.rtID);
    e.imm    = {{16{bus.rdID[4]}}, bus.rdID, bus.shamtID, bus.functID};
    e.rs     = bus.rsID;
    e.rt     = bus.rtID;
    e.shamt  = bus.shamtID;
    case (bus.opID)
      6'h00: begin
        e.dest = bus.rdID;
        e.regWrite = 1'b1;
        case (bus.functID)
          6'h20: e.aluCtrl = 4'b0010;
          6'h22: e.aluCtrl = 4'b0110;
          6'h24: e.aluCtrl = 4'b0000;
          6'h25: e.aluCtrl = 4'b0001;
          6'h2A: e.aluCtrl = 4'b0111;
          6'h00: e.aluCtrl = 4'b1000;
          6'h02: e.aluCtrl = 4'b1001;
          default: begin e.illegal = 1'b1; e.regWrite = 1'b0; e.dest = 5'd0; end
        endcase
      end
      6'h08: begin e.aluCtrl = 4'b0010; e.aluSrc = 1'b1; e.regWrite = 1'b1; e.dest = bus.rtID; end
      6'h23: begin
        e.aluCtrl = 4'b0010; e.aluSrc = 1'b1; e.memRead = 1'b1;
        e.memToReg = 1'b1; e.regWrite = 1'b1; e.dest = bus.rtID;
      end
      6'h2B: begin e.aluCtrl = 4'b0010; e.aluSrc = 1'b1; e.memWrite = 1'b1; end
      6'h04: begin e.aluCtrl = 4'b0110; e.branch = 1'b1; end
      default: e.illegal = 1'b1;
    endcase
    if (e.dest == 5'd0) e.regWrite = 1'b0;
    return e;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 32; i++) mRegs[i] = 32'd0;
    mEx = '0;
  endtask

  // Advance one clock; the model captures inputs just before the edge.
  task automatic tick();
    exp_t        nxt;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    nxt = mNext();
    we  = bus.wbEn_ID;
    wa  = bus.wbAddr_ID;
    wd  = bus.wbData_ID;
    @(posedge clk);
    if (we && wa != 5'd0) mRegs[wa] = wd;
    mEx = nxt;
    #1;
  endtask

  task automatic setR(input logic [5:0] funct, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] shamt);
    bus.opID = 6'h00; bus.rsID = rs; bus.rtID = rt; bus.rdID = rd;
    bus.shamtID = shamt; bus.functID = funct;
  endtask

  task automatic setI(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [15:0] imm);
    bus.opID = op; bus.rsID = rs; bus.rtID = rt;
    {bus.rdID, bus.shamtID, bus.functID} = imm;
  endtask

  task automatic setWb(input logic en, input logic [4:0] addr, input logic [31:0] data);
    bus.wbEn_ID = en; bus.wbAddr_ID = addr; bus.wbData_ID = data;
  endtask

  task automatic test_reset();
    nChecks++; if (actualEx() !== '0) $display("FAIL reset_idle: got %h expected 0", actualEx()); else nPass++;
    nChecks++; if (bus.stall_ID !== 1'b0) $display("FAIL reset_stall: got %b expected 0", bus.stall_ID); else nPass++;
    bus.validIn_ID = 1'b1;
    setWb(1'b1, 5'd1, 32'h0000_0011);
    setR(6'h20, 5'd1, 5'd2, 5'd3, 5'd0);
    tick();
    setWb(1'b0, 5'd0, 32'd0);
    tick();
    nChecks++;
    if ({bus.validEX, bus.rsDataEX, bus.destEX} !== {1'b1, 32'h0000_0011, 5'd3})
      $display("FAIL reset_pre_add: got %h expected %h", {bus.validEX, bus.rsDataEX, bus.destEX},
               {1'b1, 32'h0000_0011, 5'd3});
    else nPass++;
    #2 rstn = 1'b0;
    #1;
    nChecks++; if (actualEx() !== '0) $display("FAIL reset_async: got %h expected 0", actualEx()); else nPass++;
    nChecks++; if (bus.stall_ID !== 1'b0) $display("FAIL reset_async_stall: got %b expected 0", bus.stall_ID); else nPass++;
    modelReset();
    #1 rstn = 1'b1;
    tick();
    nChecks++;
    if ({bus.validEX, bus.rsDataEX} !== {1'b1, 32'd0})
      $display("FAIL reset_regs_clear: got %h expected %h", {bus.validEX, bus.rsDataEX}, {1'b1, 32'd0});
    else nPass++;
  endtask

  task automatic test_bypass();
    setWb(1'b1, 5'd5, 32'hDEAD_BEEF);
    setR(6'h20, 5'd5, 5'd0, 5'd3, 5'd0);
    tick();
    nChecks++;
    if ({bus.rsDataEX, bus.rtDataEX, bus.destEX, bus.aluCtrlEX, bus.regWriteEX} !==
        {32'hDEAD_BEEF, 32'd0, 5'd3, 4'b0010, 1'b1})
      $display("FAIL bypass_rs: got %h %h dest=%0d alu=%b rw=%b expected deadbeef 0 dest=3 alu=0010 rw=1",
               bus.rsDataEX, bus.rtDataEX, bus.destEX, bus.aluCtrlEX, bus.regWriteEX);
    else nPass++;
    setWb(1'b0, 5'd0, 32'd0);
    setR(6'h20, 5'd5, 5'd5, 5'd3, 5'd0);
    tick();
    nChecks++;
    if ({bus.rsDataEX, bus.rtDataEX} !== {32'hDEAD_BEEF, 32'hDEAD_BEEF})
      $display("FAIL bypass_stored: got %h %h expected deadbeef deadbeef", bus.rsDataEX, bus.rtDataEX);
    else nPass++;
  endtask

  task automatic test_imm_zero();
    setWb(1'b1, 5'd0, 32'h1234_5678);
    setI(6'h08, 5'd0, 5'd0, 16'hFFFC);
    tick();
    nChecks++;
    if ({bus.validEX, bus.immEX, bus.aluSrcEX, bus.regWriteEX, bus.destEX, bus.rsDataEX} !==
        {1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 5'd0, 32'd0})
      $display("FAIL imm_addi_zero: got imm=%h src=%b rw=%b dest=%0d rs=%h expected imm=fffffffc src=1 rw=0 dest=0 rs=0",
               bus.immEX, bus.aluSrcEX, bus.regWriteEX, bus.destEX, bus.rsDataEX);
    else nPass++;
    setWb(1'b0, 5'd0, 32'd0);
    setR(6'h20, 5'd0, 5'd0, 5'd1, 5'd0);
    tick();
    nChecks++;
    if ({bus.rsDataEX, bus.rtDataEX} !== 64'd0)
      $display("FAIL zero_reg_write: got %h %h expected 0 0", bus.rsDataEX, bus.rtDataEX);
    else nPass++;
  endtask

  task automatic test_load_use();
    bus.validIn_ID = 1'b0;
    tick();
    bus.validIn_ID = 1'b1;
    setI(6'h23, 5'd1, 5'd4, 16'h0000);
    tick();
    setR(6'h22, 5'd4, 5'd6, 5'd2, 5'd0);
    #1;
    nChecks++; if (bus.stall_ID !== 1'b1) $display("FAIL lu_stall_rs: got %b expected 1", bus.stall_ID); else nPass++;
    tick();
    nChecks++;
    if ({bus.validEX, bus.regWriteEX, bus.memReadEX} !== 3'b000)
      $display("FAIL lu_bubble: got %b expected 000", {bus.validEX, bus.regWriteEX, bus.memReadEX});
    else nPass++;
    nChecks++; if (bus.stall_ID !== 1'b0) $display("FAIL lu_stall_once: got %b expected 0", bus.stall_ID); else nPass++;
    tick();
    nChecks++;
    if ({bus.validEX, bus.aluCtrlEX, bus.destEX, bus.rsEX, bus.rtEX, bus.regWriteEX} !==
        {1'b1, 4'b0110, 5'd2, 5'd4, 5'd6, 1'b1})
      $display("FAIL lu_sub_issue: got %h expected %h",
               {bus.validEX, bus.aluCtrlEX, bus.destEX, bus.rsEX, bus.rtEX, bus.regWriteEX},
               {1'b1, 4'b0110, 5'd2, 5'd4, 5'd6, 1'b1});
    else nPass++;
    setI(6'h23, 5'd1, 5'd4, 16'h0000);
    tick();
    setI(6'h2B, 5'd1, 5'd4, 16'h0008);
    #1;
    nChecks++; if (bus.stall_ID !== 1'b1) $display("FAIL lu_stall_sw: got %b expected 1", bus.stall_ID); else nPass++;
    tick();
    tick();
    nChecks++;
    if ({bus.validEX, bus.memWriteEX, bus.destEX, bus.regWriteEX, bus.aluSrcEX} !== {1'b1, 1'b1, 5'd0, 1'b0, 1'b1})
      $display("FAIL lu_sw_issue: got %h expected %h",
               {bus.validEX, bus.memWriteEX, bus.destEX, bus.regWriteEX, bus.aluSrcEX},
               {1'b1, 1'b1, 5'd0, 1'b0, 1'b1});
    else nPass++;
    setI(6'h08, 5'd4, 5'd7, 16'h0001);
    #1;
    nChecks++; if (bus.stall_ID !== 1'b0) $display("FAIL lu_no_stall_nonload: got %b expected 0", bus.stall_ID); else nPass++;
    tick();
    setI(6'h23, 5'd1, 5'd4, 16'h0000);
    tick();
    setI(6'h08, 5'd0, 5'd4, 16'h0005);
    #1;
    nChecks++; if (bus.stall_ID !== 1'b0) $display("FAIL lu_no_stall_rt_dest: got %b expected 0", bus.stall_ID); else nPass++;
    tick();
    setI(6'h23, 5'd1, 5'd0, 16'h0000);
    tick();
    setR(6'h20, 5'd0, 5'd0, 5'd5, 5'd0);
    #1;
    nChecks++; if (bus.stall_ID !== 1'b0) $display("FAIL lu_no_stall_zero: got %b expected 0", bus.stall_ID); else nPass++;
    tick();
  endtask

  task automatic test_flush();
    setI(6'h23, 5'd1, 5'd4, 16'h0000);
    tick();
    setR(6'h22, 5'd4, 5'd6, 5'd2, 5'd0);
    bus.flush_ID = 1'b1;
    #1;
    nChecks++; if (bus.stall_ID !== 1'b1) $display("FAIL flush_stall_setup: got %b expected 1", bus.stall_ID); else nPass++;
    tick();
    nChecks++;
    if ({bus.validEX, bus.aluCtrlEX, bus.regWriteEX, bus.memReadEX, bus.memWriteEX, bus.memToRegEX,
         bus.aluSrcEX, bus.branchEX, bus.illegalEX} !== 12'd0)
      $display("FAIL flush_bubble: got %h expected 0",
               {bus.validEX, bus.aluCtrlEX, bus.regWriteEX, bus.memReadEX, bus.memWriteEX,
                bus.memToRegEX, bus.aluSrcEX, bus.branchEX, bus.illegalEX});
    else nPass++;
    bus.flush_ID = 1'b0;
  endtask

  task automatic test_illegal();
    setI(6'h3F, 5'd1, 5'd2, 16'h1234);
    tick();
    nChecks++;
    if ({bus.validEX, bus.illegalEX, bus.regWriteEX, bus.memReadEX, bus.memWriteEX, bus.memToRegEX, bus.branchEX} !== 7'b1100000)
      $display("FAIL illegal_op: got %b expected 1100000",
               {bus.validEX, bus.illegalEX, bus.regWriteEX, bus.memReadEX, bus.memWriteEX, bus.memToRegEX, bus.branchEX});
    else nPass++;
    setR(6'h3F, 5'd1, 5'd2, 5'd3, 5'd0);
    tick();
    nChecks++;
    if ({bus.validEX, bus.illegalEX, bus.regWriteEX, bus.memReadEX, bus.memWriteEX, bus.memToRegEX, bus.branchEX} !== 7'b1100000)
      $display("FAIL illegal_funct: got %b expected 1100000",
               {bus.validEX, bus.illegalEX, bus.regWriteEX, bus.memReadEX, bus.memWriteEX, bus.memToRegEX, bus.branchEX});
    else nPass++;
    setI(6'h04, 5'd1, 5'd2, 16'h8000);
    tick();
    nChecks++;
    if ({bus.validEX, bus.branchEX, bus.aluCtrlEX, bus.destEX, bus.regWriteEX, bus.immEX} !==
        {1'b1, 1'b1, 4'b0110, 5'd0, 1'b0, 32'hFFFF_8000})
      $display("FAIL beq_decode: got %h expected %h",
               {bus.validEX, bus.branchEX, bus.aluCtrlEX, bus.destEX, bus.regWriteEX, bus.immEX},
               {1'b1, 1'b1, 4'b0110, 5'd0, 1'b0, 32'hFFFF_8000});
    else nPass++;
  endtask

  task automatic test_random();
    logic [5:0] legalFunct [7];
    logic       hold;
    int         kind;
    legalFunct = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02};
    hold = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        kind = $urandom_range(0, 7);
        case (kind)
          0, 1: setR(($urandom_range(0, 9) == 0) ? 6'($urandom) : legalFunct[$urandom_range(0, 6)],
                     5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)), 5'($urandom));
          2:    setI(6'h08, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom));
          3, 4: setI(6'h23, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom));
          5:    setI(6'h2B, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom));
          6:    setI(6'h04, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom));
          default: setI(6'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom));
        endcase
        bus.validIn_ID = ($urandom_range(0, 7) != 0);
      end
      setWb(1'($urandom), 5'($urandom_range(0, 7)), $urandom);
      bus.flush_ID = ($urandom_range(0, 9) == 0);
      #1;
      nChecks++;
      if (bus.stall_ID !== mStall()) $display("FAIL rand_stall[%0d]: got %b expected %b", i, bus.stall_ID, mStall());
      else nPass++;
      hold = mStall() && !bus.flush_ID;
      tick();
      nChecks++;
      if (actualEx() !== mEx) $display("FAIL rand_idex[%0d]: got %h expected %h", i, actualEx(), mEx);
      else nPass++;
    end
    bus.flush_ID = 1'b0;
  endtask

  initial begin
    bus.validIn_ID = 1'b0;
    bus.flush_ID   = 1'b0;
    setR(6'h00, 5'd0, 5'd0, 5'd0, 5'd0);
    setWb(1'b0, 5'd0, 32'd0);
    modelReset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    test_reset();
    test_bypass();
    test_imm_zero();
    test_load_use();
    test_flush();
    test_illegal();
    test_random();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
